dmem_arbiter: RTL and testbench

Shares the single-ported data memory of the 1-stage RV32I core between the core's load/store port and a debug access port used for program loading, memory inspection and trace checking. Sits between the core datapath (`dmem_we`, `dmem_addr`, `dmem_wd`, `dmem_rd`) and the synchronous data RAM. It stalls the core while a read is in flight or while it has lost arbitration, and it guarantees debug forward progress through a starvation counter and a halt override.

---
 rtl/dmem_arbiter.sv | 119 +++++++++++
 tb/tb_dmem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data RAM between the core load/store port
// and the debug access port, with starvation guard and halt override.
module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            core_req,
  input  logic            core_we,
  input  logic [DW/8-1:0] core_be,
  input  logic [AW-1:0]   core_addr,
  input  logic [DW-1:0]   core_wd,
  output logic            core_stall,
  output logic            core_rvalid,
  output logic [DW-1:0]   core_rd,
  input  logic            dbg_valid,
  output logic            dbg_ready,
  input  logic            dbg_we,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [DW-1:0]   dbg_wd,
  input  logic            dbg_halt,
  output logic            dbg_rvalid,
  output logic [DW-1:0]   dbg_rd,
  output logic            dbg_err,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wd,
  input  logic [DW-1:0]   mem_rd
);

  typedef enum logic [1:0] {
    IDLE,
    CORE_RD,
    DBG_RD
  } rd_state_t;

  rd_state_t  rd_state;
  rd_state_t  rd_next;
  logic [3:0] starve_cnt;
  logic       err_q;

  logic core_elig;
  logic dbg_pri;
  logic dbg_gnt;
  logic core_gnt;
  logic dbg_mis;

  assign dbg_mis   = |dbg_addr[1:0];
  assign core_elig = rst_n && core_req && (rd_state != CORE_RD);
  assign dbg_pri   = dbg_halt ||
                     (starve_cnt >= 4'(STARVE_LIMIT));
  assign dbg_gnt   = rst_n && dbg_valid &&
                     (dbg_pri || !core_elig);
  assign core_gnt  = core_elig && !dbg_gnt;

  assign dbg_ready = dbg_gnt;

  // a core read is answered in CORE_RD, so it must not stall there
  assign core_stall = core_req &&
                      !(core_gnt && core_we) &&
                      (rd_state != CORE_RD);

  assign core_rvalid = (rd_state == CORE_RD);
  assign core_rd     = core_rvalid ? mem_rd : '0;

  assign dbg_rvalid = (rd_state == DBG_RD) || err_q;
  assign dbg_rd     = (rd_state == DBG_RD) ? mem_rd : '0;
  assign dbg_err    = err_q;

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_be   = '0;
    mem_addr = '0;
    mem_wd   = '0;
    rd_next  = IDLE;
    unique case (1'b1)
      dbg_gnt: begin
        mem_en   = !dbg_mis;
        mem_we   = dbg_we && !dbg_mis;
        mem_be   = '1;
        mem_addr = dbg_addr;
        mem_wd   = dbg_wd;
        if (!dbg_we && !dbg_mis)
          rd_next = DBG_RD;
      end
      core_gnt: begin
        mem_en   = 1'b1;
        mem_we   = core_we;
        mem_be   = core_be;
        mem_addr = core_addr;
        mem_wd   = core_wd;
        if (!core_we)
          rd_next = CORE_RD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state   <= IDLE;
      starve_cnt <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      rd_state <= rd_next;
      err_q    <= dbg_gnt && dbg_mis;
      if (!dbg_valid || dbg_gnt)
        starve_cnt <= 4'd0;
      else if (starve_cnt != 4'hF)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench with RAM model and response
// scoreboard for the data memory arbiter.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        core_req;
  logic        core_we;
  logic [3:0]  core_be;
  logic [31:0] core_addr;
  logic [31:0] core_wd;
  logic        core_stall;
  logic        core_rvalid;
  logic [31:0] core_rd;
  logic        dbg_valid;
  logic        dbg_ready;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wd;
  logic        dbg_halt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rd;
  logic        dbg_err;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  int errors = 0;
  int checks = 0;

  logic [31:0] core_q[$];
  logic [32:0] dbg_q[$];

  logic [31:0] ram [0:255];
  logic        ram_init;
  int          en_cnt;
  int          en0;

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_be(core_be),
    .core_addr(core_addr), .core_wd(core_wd),
    .core_stall(core_stall), .core_rvalid(core_rvalid),
    .core_rd(core_rd),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wd(dbg_wd), .dbg_halt(dbg_halt),
    .dbg_rvalid(dbg_rvalid), .dbg_rd(dbg_rd), .dbg_err(dbg_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous RAM: read data one cycle after the command
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      ram[64] <= 32'hDEADBEEF;
      mem_rd  <= 32'h0;
      en_cnt  <= 0;
    end else if (mem_en) begin
      en_cnt <= en_cnt + 1;
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b])
            ram[mem_addr[9:2]][8*b +: 8] <= mem_wd[8*b +: 8];
      end else begin
        mem_rd <= ram[mem_addr[9:2]];
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (core_rvalid === 1'b1) begin
      if (core_q.size() == 0)
        check("core_rvalid_unexpected", 32'(core_rvalid), 0);
      else
        check("core_rd", core_rd, core_q.pop_front());
    end
    if (dbg_rvalid === 1'b1) begin
      if (dbg_q.size() == 0) begin
        check("dbg_rvalid_unexpected", 32'(dbg_rvalid), 0);
      end else begin
        logic [32:0] e;
        e = dbg_q.pop_front();
        check("dbg_rd", dbg_rd, e[31:0]);
        check("dbg_err", 32'(dbg_err), 32'(e[32]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    core_req  = 0; core_we = 0; core_be = 4'hF;
    core_addr = 0; core_wd = 0;
    dbg_valid = 0; dbg_we = 0; dbg_addr = 0;
    dbg_wd    = 0; dbg_halt = 0;
  endtask

  initial begin
    clear_inputs();
    rst_n    = 0;
    ram_init = 1;
    core_req = 1;
    @(negedge clk);
    ram_init = 0;
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_dbg_ready", 32'(dbg_ready), 0);
    check("rst_stall_follows", 32'(core_stall), 1);
    check("rst_dbg_rvalid", 32'(dbg_rvalid), 0);
    check("rst_dbg_err", 32'(dbg_err), 0);
    check("rst_state", 32'(dut.rd_state), 0);
    check("rst_starve", 32'(dut.starve_cnt), 0);
    core_req = 0;
    next_cycle();
    rst_n = 1;

    // core load of 0x100
    next_cycle();
    core_req = 1; core_addr = 32'h100;
    @(negedge clk);
    check("ld_stall0", 32'(core_stall), 1);
    check("ld_mem_en", 32'(mem_en), 1);
    check("ld_rvalid0", 32'(core_rvalid), 0);
    core_q.push_back(32'hDEADBEEF);
    en0 = en_cnt;
    next_cycle();
    @(negedge clk);
    check("ld_stall1", 32'(core_stall), 0);
    check("ld_rvalid1", 32'(core_rvalid), 1);
    check("ld_mem_en1", 32'(mem_en), 0);
    check("ld_en_pulses", en_cnt - en0, 1);

    // core partial store, then debug read back
    next_cycle();
    core_we = 1; core_be = 4'b0011;
    core_addr = 32'h20; core_wd = 32'h12345678;
    @(negedge clk);
    check("st_mem_be", 32'(mem_be), 32'h3);
    check("st_mem_we", 32'(mem_we), 1);
    check("st_stall", 32'(core_stall), 0);
    next_cycle();
    clear_inputs();
    dbg_valid = 1; dbg_addr = 32'h20;
    @(negedge clk);
    check("drd_ready", 32'(dbg_ready), 1);
    dbg_q.push_back({1'b0, 32'h00005678});
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("drd_rvalid", 32'(dbg_rvalid), 1);

    // starvation: core writes every cycle, debug write pending
    next_cycle();
    core_req = 1; core_we = 1; core_be = 4'hF;
    core_addr = 32'h40; core_wd = 32'h11112222;
    dbg_valid = 1; dbg_we = 1;
    dbg_addr = 32'h44; dbg_wd = 32'hCAFEF00D;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("stv_ready_%0d", i), 32'(dbg_ready),
            (i == 5) ? 1 : 0);
      check($sformatf("stv_cnt_%0d", i), 32'(dut.starve_cnt), i - 1);
      if (i == 5) check("stv_stall", 32'(core_stall), 1);
      next_cycle();
    end
    @(negedge clk);
    check("stv_cnt_clr", 32'(dut.starve_cnt), 0);
    check("stv_core_wins", 32'(dbg_ready), 0);

    // halt: 8 back-to-back debug writes while core wants a load
    next_cycle();
    clear_inputs();
    core_req = 1; core_addr = 32'h100;
    dbg_halt = 1; dbg_valid = 1; dbg_we = 1;
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 32'h80 + 32'(4 * i);
      dbg_wd   = 32'hA0 + 32'(i);
      @(negedge clk);
      check($sformatf("halt_ready_%0d", i), 32'(dbg_ready), 1);
      check($sformatf("halt_stall_%0d", i), 32'(core_stall), 1);
      next_cycle();
    end
    dbg_halt = 0; dbg_valid = 0; dbg_we = 0;
    @(negedge clk);
    check("halt_ld_grant", 32'(mem_en), 1);
    check("halt_ld_stall", 32'(core_stall), 1);
    core_q.push_back(32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    check("halt_ld_done", 32'(core_rvalid), 1);
    next_cycle();
    clear_inputs();
    dbg_valid = 1; dbg_addr = 32'h8C;
    @(negedge clk);
    check("halt_rb_ready", 32'(dbg_ready), 1);
    dbg_q.push_back({1'b0, 32'h000000A3});
    next_cycle();
    clear_inputs();
    dbg_valid = 1; dbg_addr = 32'h44;
    @(negedge clk);
    dbg_q.push_back({1'b0, 32'hCAFEF00D});

    // misaligned debug read
    next_cycle();
    clear_inputs();
    dbg_valid = 1; dbg_addr = 32'h102;
    @(negedge clk);
    check("mis_ready", 32'(dbg_ready), 1);
    check("mis_mem_en", 32'(mem_en), 0);
    dbg_q.push_back({1'b1, 32'h0});
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("mis_rvalid", 32'(dbg_rvalid), 1);
    check("mis_err", 32'(dbg_err), 1);

    // reset while a core read is in flight
    next_cycle();
    core_req = 1; core_addr = 32'h100;
    @(negedge clk);
    check("mrst_stall0", 32'(core_stall), 1);
    core_q.push_back(32'hDEADBEEF);
    next_cycle();
    rst_n = 0;
    core_q.delete();
    @(negedge clk);
    check("mrst_core_rvalid", 32'(core_rvalid), 0);
    check("mrst_dbg_rvalid", 32'(dbg_rvalid), 0);
    check("mrst_dbg_err", 32'(dbg_err), 0);
    check("mrst_state", 32'(dut.rd_state), 0);
    check("mrst_starve", 32'(dut.starve_cnt), 0);
    check("mrst_mem_en", 32'(mem_en), 0);
    check("mrst_stall", 32'(core_stall), 1);
    next_cycle();
    rst_n = 1;
    @(negedge clk);
    check("mrst_reissue", 32'(mem_en), 1);
    check("mrst_no_rvalid", 32'(core_rvalid), 0);
    core_q.push_back(32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    check("mrst_rvalid", 32'(core_rvalid), 1);
    next_cycle();
    clear_inputs();
    repeat (2) @(negedge clk);

    check("core_q_empty", 32'(core_q.size()), 0);
    check("dbg_q_empty", 32'(dbg_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
